float_mul_seq: RTL and testbench
================================

// Module: float_mul_seq
// PURPOSE
//  Parametrised sequential IEEE-754-style floating-point multiplier; successor to the
//  combinational float multiplier. Configurable exponent/mantissa widths, valid/ready
//  handshake on both sides, iterative shift-add mantissa core, round-to-nearest-even,
//  full special-case handling. Sits between operand staging and the accumulator datapath.
// PARAMETERS
//  EXP_W  8   exponent field width (>=3); BIAS = 2^(EXP_W-1)-1
//  MAN_W  23  stored fraction width (>=2); word width W = 1+EXP_W+MAN_W
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  asynchronous active-low reset
//  in_valid   in   1  operands a/b valid
//  in_ready   out  1  block can accept operands (high only in IDLE)
//  a          in   W  operand A {sign, exp, frac}
//  b          in   W  operand B
//  out_valid  out  1  product valid (high only in DONE)
//  out_ready  in   1  consumer accepts product
//  product    out  W  result; held stable while out_valid && !out_ready
//  flags      out  4  {invalid, overflow, underflow, inexact}, valid with product
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, product=0, flags=0,
//   all datapath regs cleared. Reset mid-operation aborts; the partial result is discarded.
//  FSM: IDLE -> UNPACK -> MUL -> NORM -> ROUND -> DONE -> IDLE.
//   IDLE:   in_ready=1; on in_valid&&in_ready, capture a/b, go UNPACK.
//   UNPACK: split fields; sign = sA^sB; exp_sum = eA+eB-BIAS in EXP_W+2-bit signed;
//           classify zero/inf/NaN; exp field 0 (subnormal) treated as zero (FTZ).
//   MUL:    exactly MAN_W+1 cycles; each cycle examines one multiplier bit (LSB first)
//           of 1.fracB, conditionally adds 1.fracA to a 2*(MAN_W+1)-bit accumulator.
//   NORM:   if product bit 2*MAN_W+1 set, shift right 1, exp_sum+1; form guard bit and
//           sticky = OR of all lower bits.
//   ROUND:  RNE: increment if guard && (sticky || lsb); mantissa carry-out renormalises
//           (exp+1). Then range check: exp>=2^EXP_W-1 -> +/-inf, overflow=1, inexact=1;
//           exp<=0 -> signed zero, underflow=1, inexact=1 (no subnormal output).
//   DONE:   out_valid=1; product/flags stable; on out_ready go IDLE (in_ready rises
//           next cycle; no same-cycle re-accept).
//  Latency: fixed; out_valid rises MAN_W+4 clock edges after the accepting edge, for
//   every operand class (specials still traverse MUL; result overridden at ROUND).
//  Throughput: one operation per MAN_W+5 cycles minimum, plus consumer stall cycles.
//  Special cases (priority order):
//   any NaN input, or 0*inf -> canonical qNaN {0, all-ones exp, 1, zeros}, invalid=1
//   inf * finite nonzero -> signed inf, no flags
//   zero (incl. flushed subnormal) * finite -> signed zero, no flags
//  inexact=1 whenever guard||sticky was nonzero in a finite result.
//  in_valid while busy is ignored (in_ready=0); a/b sampled only on the accepting edge.
// TESTING (EXP_W=8, MAN_W=23 unless stated; all checks on out_valid)
//  a=3FC00000, b=40000000 -> product=40400000 (1.5*2=3), flags=0, out_valid 27 edges after accept
//  a=BF800000, b=3FC00000 -> BFC00000; a=3F800001, b=3F800001 -> 3F800002, inexact=1
//  RNE tie: a=3F800001, b=3FC00000 -> 3FC00002, inexact=1 (tie to even)
//  a=00000000, b=7F800000 -> 7FC00000, invalid=1; a=7F000000, b=7F000000 -> 7F800000,
//   overflow=1; a=00800000, b=00800000 -> 00000000, underflow=1
//  Backpressure: hold out_ready=0 for 10 cycles -> product/out_valid stable, in_ready=0;
//   then pulse rst_n low mid-MUL of next op -> out_valid=0, in_ready=1 immediately
//  EXP_W=5, MAN_W=10: a=3C00, b=4000 -> 4000; a=C200, b=4200 -> C880 (-3*3=-9)

Source files
------------

// File: rtl/float_mul_seq.sv
// rtl/float_mul_seq.sv - sequential shift-add floating-point multiplier with RNE rounding
// Valid/ready on both sides; fixed MAN_W+4 cycle latency for every operand class.
module float_mul_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [EXP_W+MAN_W:0]     a,
   input  logic [EXP_W+MAN_W:0]     b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+MAN_W:0]     product,
   output logic [3:0]               flags
);
   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int PW   = 2 * (MAN_W + 1);
   localparam int SE   = EXP_W + 2;
   localparam int CW   = $clog2(MAN_W + 1);
   localparam logic signed [SE-1:0] BIAS = SE'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [SE-1:0] EMAX = SE'((1 << EXP_W) - 1);

   typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MUL, S_NORM, S_ROUND, S_DONE} state_t;
   state_t state, state_nx;

   logic [W-1:0]           a_r, b_r;
   logic                   sign_r, nan_r, inf_r, zero_r;
   logic signed [SE-1:0]   exp_r;
   logic [PW-1:0]          ma_sh, acc;
   logic [MAN_W:0]         mb_r, mant_r;
   logic [CW-1:0]          cnt;
   logic                   guard_r, sticky_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = S_UNPACK;
         end
         S_UNPACK: state_nx = S_MUL;
         S_MUL:    if (cnt == CW'(MAN_W)) state_nx = S_NORM;
         S_NORM:   state_nx = S_ROUND;
         S_ROUND:  state_nx = S_DONE;
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = S_IDLE;
         end
         default:  state_nx = S_IDLE;
      endcase
   end

   // Operand field split and classification (subnormals flush to zero)
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   always_comb begin
      ea     = a_r[W-2:MAN_W];
      eb     = b_r[W-2:MAN_W];
      fa     = a_r[MAN_W-1:0];
      fb     = b_r[MAN_W-1:0];
      a_zero = (ea == '0);
      b_zero = (eb == '0);
      a_inf  = (ea == '1) && (fa == '0);
      b_inf  = (eb == '1) && (fb == '0);
      a_nan  = (ea == '1) && (fa != '0);
      b_nan  = (eb == '1) && (fb != '0);
   end

   logic                   rnd_up, ovf, unf;
   logic [MAN_W+1:0]       mant_rnd;
   logic signed [SE-1:0]   exp_fin;
   logic [MAN_W-1:0]       frac_fin;
   always_comb begin
      rnd_up   = guard_r & (sticky_r | mant_r[0]);
      mant_rnd = {1'b0, mant_r} + (MAN_W+2)'(rnd_up);
      exp_fin  = exp_r + SE'(mant_rnd[MAN_W+1]);
      frac_fin = mant_rnd[MAN_W+1] ? mant_rnd[MAN_W:1] : mant_rnd[MAN_W-1:0];
      ovf      = (exp_fin >= EMAX);
      unf      = (exp_fin <= 0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r <= '0; b_r <= '0; sign_r <= 1'b0; nan_r <= 1'b0; inf_r <= 1'b0; zero_r <= 1'b0;
         exp_r <= '0; ma_sh <= '0; acc <= '0; mb_r <= '0; mant_r <= '0; cnt <= '0;
         guard_r <= 1'b0; sticky_r <= 1'b0; product <= '0; flags <= '0;
      end else begin
         case (state)
            S_IDLE: if (in_valid) begin
               a_r <= a;
               b_r <= b;
            end
            S_UNPACK: begin
               sign_r <= a_r[W-1] ^ b_r[W-1];
               exp_r  <= SE'(ea) + SE'(eb) - BIAS;
               ma_sh  <= PW'({1'b1, fa});
               mb_r   <= {1'b1, fb};
               acc    <= '0;
               cnt    <= '0;
               nan_r  <= a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero);
               inf_r  <= a_inf | b_inf;
               zero_r <= a_zero | b_zero;
            end
            S_MUL: begin
               if (mb_r[0]) acc <= acc + ma_sh;
               ma_sh <= ma_sh << 1;
               mb_r  <= mb_r >> 1;
               cnt   <= cnt + 1'b1;
            end
            S_NORM: begin
               if (acc[PW-1]) begin
                  mant_r   <= acc[PW-1:MAN_W+1];
                  guard_r  <= acc[MAN_W];
                  sticky_r <= |acc[MAN_W-1:0];
                  exp_r    <= exp_r + 1'b1;
               end else begin
                  mant_r   <= acc[PW-2:MAN_W];
                  guard_r  <= acc[MAN_W-1];
                  sticky_r <= |acc[MAN_W-2:0];
               end
            end
            S_ROUND: begin
               if (nan_r) begin
                  product <= {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                  flags   <= 4'b1000;
               end else if (inf_r) begin
                  product <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                  flags   <= 4'b0000;
               end else if (zero_r) begin
                  product <= {sign_r, {(W-1){1'b0}}};
                  flags   <= 4'b0000;
               end else if (ovf) begin
                  product <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                  flags   <= 4'b0101;
               end else if (unf) begin
                  product <= {sign_r, {(W-1){1'b0}}};
                  flags   <= 4'b0011;
               end else begin
                  product <= {sign_r, exp_fin[EXP_W-1:0], frac_fin};
                  flags   <= {3'b000, guard_r | sticky_r};
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_float_mul_seq.sv
// tb/tb_float_mul_seq.sv - scoreboard bench for float_mul_seq (8/23 and 5/10 instances)
// Expected results come from an integer-arithmetic reference model of the rounding rules.
module tb_float_mul_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid0 = 0, in_ready0, out_valid0, out_ready0 = 1;
   logic [31:0] a0 = 0, b0 = 0, product0;
   logic [3:0]  flags0;
   logic        in_valid1 = 0, in_ready1, out_valid1, out_ready1 = 1;
   logic [15:0] a1 = 0, b1 = 0, product1;
   logic [3:0]  flags1;

   float_mul_seq #(.EXP_W(8), .MAN_W(23)) d0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0), .a(a0), .b(b0),
      .out_valid(out_valid0), .out_ready(out_ready0), .product(product0), .flags(flags0));
   float_mul_seq #(.EXP_W(5), .MAN_W(10)) d1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
      .out_valid(out_valid1), .out_ready(out_ready1), .product(product1), .flags(flags1));

   int tests = 0, fails = 0, cyc = 0;
   logic [35:0] sb0[$], sb1[$];
   int lat0[$], lat1[$];
   logic pv0 = 0, pv1 = 0, rnd_rdy = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic timeout(input string name);
      tests++;
      fails++;
      $display("FAIL %s timeout", name);
   endtask

   // Returns {flags, product}: exact integer product, then RNE by quotient/remainder
   function automatic logic [35:0] ref_mul(input int ew, input int mw, input logic [31:0] x, input logic [31:0] y);
      longint emax = (longint'(1) << ew) - 1;
      longint bias = (longint'(1) << (ew - 1)) - 1;
      longint one  = longint'(1) << mw;
      longint ex = (longint'(x) >> mw) & emax, ey = (longint'(y) >> mw) & emax;
      longint fx = longint'(x) & (one - 1), fy = longint'(y) & (one - 1);
      logic   s  = x[ew+mw] ^ y[ew+mw];
      logic [31:0] sg = s ? (32'd1 << (ew + mw)) : 32'd0;
      logic [31:0] inf = sg | 32'(emax << mw);
      logic xn = (ex == emax) && (fx != 0), yn = (ey == emax) && (fy != 0);
      logic xi = (ex == emax) && (fx == 0), yi = (ey == emax) && (fy == 0);
      logic xz = (ex == 0), yz = (ey == 0);
      longint p, q, rem, half, e;
      int sh;
      if (xn || yn || (xz && yi) || (xi && yz))
         return {4'b1000, 32'((emax << mw) | (longint'(1) << (mw - 1)))};
      if (xi || yi) return {4'b0000, inf};
      if (xz || yz) return {4'b0000, sg};
      p  = (one + fx) * (one + fy);
      e  = ex + ey - bias;
      sh = mw;
      if (p >= (longint'(1) << (2 * mw + 1))) begin
         sh = mw + 1;
         e++;
      end
      q    = p >> sh;
      rem  = p - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (one << 1)) begin
         q = q >> 1;
         e++;
      end
      if (e >= emax) return {4'b0101, inf};
      if (e <= 0)    return {4'b0011, sg};
      return {3'b000, rem != 0, sg | 32'(e << mw) | 32'(q - one)};
   endfunction

   function automatic logic [31:0] gen(input int ew, input int mw);
      int emax = (1 << ew) - 1, bias = (1 << (ew - 1)) - 1, r = $urandom_range(0, 9);
      logic [31:0] e, f;
      if (r == 0)      e = 0;
      else if (r == 1) e = emax;
      else if (r == 2) e = $urandom_range(1, emax - 1);
      else             e = $urandom_range(bias - bias / 2, bias + bias / 2);
      f = $urandom & ((32'd1 << mw) - 1);
      if ($urandom_range(0, 3) == 0) f = (r == 1) ? 0 : f & 32'h7;
      return (32'($urandom_range(0, 1)) << (ew + mw)) | (e << mw) | f;
   endfunction

   task automatic issue0(input logic [31:0] x, input logic [31:0] y, input logic [35:0] req);
      int n = 0;
      @(posedge clk); #1;
      while (!in_ready0 && n < 300) begin @(posedge clk); #1; n++; end
      if (!in_ready0) begin timeout("d0_accept"); return; end
      a0 = x; b0 = y; in_valid0 = 1;
      sb0.push_back(req);
      @(posedge clk); #1;
      lat0.push_back(cyc);
      in_valid0 = 0; a0 = $urandom; b0 = $urandom;
   endtask

   task automatic issue1(input logic [15:0] x, input logic [15:0] y, input logic [35:0] req);
      int n = 0;
      @(posedge clk); #1;
      while (!in_ready1 && n < 300) begin @(posedge clk); #1; n++; end
      if (!in_ready1) begin timeout("d1_accept"); return; end
      a1 = x; b1 = y; in_valid1 = 1;
      sb1.push_back(req);
      @(posedge clk); #1;
      lat1.push_back(cyc);
      in_valid1 = 0; a1 = 16'($urandom); b1 = 16'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while ((sb0.size() != 0 || sb1.size() != 0) && n < 5000) begin @(posedge clk); n++; end
      if (sb0.size() != 0 || sb1.size() != 0) timeout("drain");
   endtask

   // Monitor: latency on the rising edge of out_valid, value on each handshake
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid0 && !pv0) begin
            if (lat0.size() == 0) timeout("d0_unexpected_valid");
            else chk("d0_latency", 64'(cyc - lat0.pop_front()), 64'd27);
         end
         if (out_valid0 && out_ready0) begin
            if (sb0.size() == 0) timeout("d0_unexpected_result");
            else chk("d0_result", {flags0, product0}, sb0.pop_front());
         end
         if (out_valid1 && !pv1) begin
            if (lat1.size() == 0) timeout("d1_unexpected_valid");
            else chk("d1_latency", 64'(cyc - lat1.pop_front()), 64'd14);
         end
         if (out_valid1 && out_ready1) begin
            if (sb1.size() == 0) timeout("d1_unexpected_result");
            else chk("d1_result", {flags1, 16'h0, product1}, sb1.pop_front());
         end
      end
      pv0 = out_valid0;
      pv1 = out_valid1;
   end

   initial begin
      forever begin
         @(posedge clk); #2;
         if (rnd_rdy) begin
            out_ready0 = ($urandom_range(0, 2) != 0);
            out_ready1 = ($urandom_range(0, 2) != 0);
         end
      end
   end

   initial begin
      logic [31:0] x, y;
      int n;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_d0", {in_ready0, out_valid0, flags0, product0}, {1'b1, 1'b0, 4'h0, 32'h0});
      chk("rst_d1", {in_ready1, out_valid1, flags1, product1}, {1'b1, 1'b0, 4'h0, 16'h0});
      rst_n = 1;

      issue0(32'h3FC00000, 32'h40000000, {4'b0000, 32'h40400000});
      in_valid0 = 1;
      repeat (10) begin @(posedge clk); #1; a0 = $urandom; b0 = $urandom; end
      in_valid0 = 0;
      issue0(32'hBF800000, 32'h3FC00000, {4'b0000, 32'hBFC00000});
      issue0(32'h3F800001, 32'h3F800001, {4'b0001, 32'h3F800002});
      issue0(32'h3F800001, 32'h3FC00000, {4'b0001, 32'h3FC00002});
      issue0(32'h00000000, 32'h7F800000, {4'b1000, 32'h7FC00000});
      issue0(32'h7F000000, 32'h7F000000, {4'b0101, 32'h7F800000});
      issue0(32'h00800000, 32'h00800000, {4'b0011, 32'h00000000});
      issue0(32'h7FC00001, 32'h3F800000, {4'b1000, 32'h7FC00000});
      issue0(32'hFF800000, 32'h40000000, {4'b0000, 32'hFF800000});
      issue0(32'h80000000, 32'h3F800000, {4'b0000, 32'h80000000});
      issue0(32'h00400000, 32'h40000000, {4'b0000, 32'h00000000});
      issue1(16'h3C00, 16'h4000, {4'b0000, 32'h4000});
      issue1(16'hC200, 16'h4200, {4'b0000, 32'hC880});
      issue1(16'h7C00, 16'h0000, {4'b1000, 32'h7E00});
      drain();

      rnd_rdy = 1;
      for (int i = 0; i < 150; i++) begin
         x = gen(8, 23); y = gen(8, 23);
         issue0(x, y, ref_mul(8, 23, x, y));
      end
      for (int i = 0; i < 150; i++) begin
         x = gen(5, 10); y = gen(5, 10);
         issue1(16'(x), 16'(y), ref_mul(5, 10, x, y));
      end
      rnd_rdy = 0;
      @(posedge clk); #1;
      out_ready0 = 1; out_ready1 = 1;
      drain();

      out_ready0 = 0;
      issue0(32'h3FC00000, 32'h40000000, {4'b0000, 32'h40400000});
      n = 0;
      @(negedge clk);
      while (!out_valid0 && n < 100) begin @(negedge clk); n++; end
      if (!out_valid0) timeout("bp_valid");
      repeat (10) begin
         @(negedge clk);
         chk("bp_hold", {in_ready0, out_valid0, flags0, product0}, {1'b0, 1'b1, 4'h0, 32'h40400000});
      end
      @(posedge clk); #1;
      out_ready0 = 1;
      issue0(32'h3F800001, 32'h3F800001, {4'b0001, 32'h3F800002});
      repeat (5) @(posedge clk);
      #1;
      rst_n = 0;
      #1;
      chk("mid_rst", {in_ready0, out_valid0, flags0, product0}, {1'b1, 1'b0, 4'h0, 32'h0});
      if (sb0.size() != 0) void'(sb0.pop_back());
      if (lat0.size() != 0) void'(lat0.pop_back());
      @(posedge clk); #1;
      rst_n = 1;
      issue0(32'hBF800000, 32'h3FC00000, {4'b0000, 32'hBFC00000});
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
